// File: rtl/ycr1_reset_seq_cell.sv
// ==========================================================================
// ycr1_reset_seq_cell : multi-channel reset sequencer with sw stretch (rev 1.0)
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module ycr1_reset_seq_cell #(
  parameter int CH_NUM         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int STRETCH_CYCLES = 8,
  parameter int CNT_W          = $clog2(((GAP_CYCLES > STRETCH_CYCLES) ? GAP_CYCLES
                                                                      : STRETCH_CYCLES) + 1)
) (
  input  logic              clk,
  input  logic              rst_n_mux,
  input  logic              test_mode,
  input  logic              test_rst_n,
  input  logic              rst_n_in,
  input  logic [CH_NUM-1:0] sw_rst_req,
  output logic [CH_NUM-1:0] rst_n_out,
  output logic [CH_NUM-1:0] rst_n_status,
  output logic              seq_busy,
  output logic              seq_done
);

  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(CH_NUM - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CH_NUM-1:0]      rel_q, rel_d;
  logic [CH_NUM-1:0]      out_q, out_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       scnt_q [CH_NUM];
  logic [CNT_W-1:0]       scnt_d [CH_NUM];
  logic                   s;

  if (SYNC_STAGES == 1) begin : g_sync_single
    always_comb sync_d = rst_n_in;
  end else begin : g_sync_chain
    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], rst_n_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    done_d  = 1'b0;
    for (int i = 0; i < CH_NUM; i++) scnt_d[i] = '0;

    // A dropped request wins over everything except the async reset
    if (!s) begin
      state_d = ST_HOLD;
      idx_d   = '0;
      cnt_d   = '0;
      rel_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_d = ST_RELEASE;
          idx_d   = '0;
          cnt_d   = '0;
          rel_d   = '0;
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            for (int i = 0; i < CH_NUM; i++) begin
              if (idx_q == IDX_W'(i)) rel_d[i] = 1'b1;
            end
            if (idx_q == LAST_IDX) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          // Each new request re-arms the full stretch width
          for (int i = 0; i < CH_NUM; i++) begin
            if (sw_rst_req[i])         scnt_d[i] = STRETCH_LOAD;
            else if (scnt_q[i] != '0)  scnt_d[i] = scnt_q[i] - 1'b1;
            else                       scnt_d[i] = '0;
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end

    for (int i = 0; i < CH_NUM; i++) out_d[i] = rel_d[i] & (scnt_d[i] == '0);
  end

  always_ff @(posedge clk or negedge rst_n_mux) begin
    if (!rst_n_mux) begin
      sync_q  <= '0;
      state_q <= ST_HOLD;
      idx_q   <= '0;
      cnt_q   <= '0;
      rel_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) scnt_q[i] <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      out_q   <= out_d;
      done_q  <= done_d;
      scnt_q  <= scnt_d;
    end
  end

  assign rst_n_out    = test_mode ? {CH_NUM{test_rst_n}} : out_q;
  assign rst_n_status = out_q;
  assign seq_busy     = (state_q != ST_RUN);
  assign seq_done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ycr1_reset_seq_cell.sv
// ==========================================================================
// tb_ycr1_reset_seq_cell : scoreboard bench for the reset sequencer (rev 1.0)
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ycr1_reset_seq_cell;

  logic       clk = 1'b0;
  logic       rst_n_mux, test_mode, test_rst_n;
  logic       rst_n_in_a, rst_n_in_b;
  logic [3:0] sw_a;
  logic       sw_b;
  logic [3:0] out_a, st_a;
  logic       busy_a, done_a;
  logic       out_b, st_b, busy_b, done_b;

  always #5 clk = ~clk;

  ycr1_reset_seq_cell u_dut_a (
    .clk          (clk),
    .rst_n_mux    (rst_n_mux),
    .test_mode    (test_mode),
    .test_rst_n   (test_rst_n),
    .rst_n_in     (rst_n_in_a),
    .sw_rst_req   (sw_a),
    .rst_n_out    (out_a),
    .rst_n_status (st_a),
    .seq_busy     (busy_a),
    .seq_done     (done_a)
  );

  ycr1_reset_seq_cell #(
    .CH_NUM(1), .GAP_CYCLES(1), .STRETCH_CYCLES(1)
  ) u_dut_b (
    .clk          (clk),
    .rst_n_mux    (rst_n_mux),
    .test_mode    (test_mode),
    .test_rst_n   (test_rst_n),
    .rst_n_in     (rst_n_in_b),
    .sw_rst_req   (sw_b),
    .rst_n_out    (out_b),
    .rst_n_status (st_b),
    .seq_busy     (busy_b),
    .seq_done     (done_b)
  );

  typedef struct {
    int         e;
    bit         b;
    logic [3:0] out;
    logic [3:0] st;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   edge_no = 0;

  task automatic cmp(input string tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_no, act, exp);
    end
  endtask

  // Channels k < ch that have been released by edge e when RELEASE began at base
  function automatic logic [3:0] rel_mask(input int e, input int base, input int gap,
                                          input int ch);
    logic [3:0] m;
    m = '0;
    for (int k = 0; k < ch; k++) if (e >= base + gap * (k + 1)) m[k] = 1'b1;
    return m;
  endfunction

  task automatic push_a(input int e, input logic [3:0] out, input logic [3:0] st,
                        input logic busy, input logic done);
    q.push_back('{e: e, b: 1'b0, out: out, st: st, busy: busy, done: done});
  endtask

  task automatic push_b(input int e, input logic out, input logic st,
                        input logic busy, input logic done);
    q.push_back('{e: e, b: 1'b1, out: {3'b0, out}, st: {3'b0, st}, busy: busy, done: done});
  endtask

  task automatic check_due();
    exp_t x;
    while (q.size() != 0 && q[0].e <= edge_no) begin
      x = q.pop_front();
      if (x.b) begin
        cmp("b_out",    {3'b0, out_b},  x.out);
        cmp("b_status", {3'b0, st_b},   x.st);
        cmp("b_busy",   {3'b0, busy_b}, {3'b0, x.busy});
        cmp("b_done",   {3'b0, done_b}, {3'b0, x.done});
      end else begin
        cmp("a_out",    out_a,          x.out);
        cmp("a_status", st_a,           x.st);
        cmp("a_busy",   {3'b0, busy_a}, {3'b0, x.busy});
        cmp("a_done",   {3'b0, done_a}, {3'b0, x.done});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_no++;
    #1;
    check_due();
  endtask

  task automatic run_to(input int e);
    while (edge_no < e) tick();
  endtask

  task automatic check_reset_now(input string tag);
    cmp({tag, "_a_out"},    out_a,           4'h0);
    cmp({tag, "_a_status"}, st_a,            4'h0);
    cmp({tag, "_a_busy"},   {3'b0, busy_a},  4'h1);
    cmp({tag, "_a_done"},   {3'b0, done_a},  4'h0);
    cmp({tag, "_b_out"},    {3'b0, out_b},   4'h0);
    cmp({tag, "_b_status"}, {3'b0, st_b},    4'h0);
    cmp({tag, "_b_busy"},   {3'b0, busy_b},  4'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d observed=timeout expected=finish", edge_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] m;

    rst_n_mux  = 1'b0;
    test_mode  = 1'b0;
    test_rst_n = 1'b0;
    rst_n_in_a = 1'b0;
    rst_n_in_b = 1'b0;
    sw_a       = 4'h0;
    sw_b       = 1'b0;
    #3;
    check_reset_now("por");
    test_mode  = 1'b1;
    test_rst_n = 1'b1;
    #1;
    cmp("por_tm_a_out",    out_a,          4'hF);
    cmp("por_tm_a_status", st_a,           4'h0);
    cmp("por_tm_b_out",    {3'b0, out_b},  4'h1);
    test_mode  = 1'b0;
    test_rst_n = 1'b0;

    // Run 1: full release from reset
    @(negedge clk);
    rst_n_mux  = 1'b1;
    rst_n_in_a = 1'b1;
    rst_n_in_b = 1'b1;
    edge_no    = 0;
    for (int e = 1; e <= 29; e++) begin
      push_a(e, rel_mask(e, 3, 4, 4), rel_mask(e, 3, 4, 4), e < 19, e == 19);
      push_b(e, rel_mask(e, 3, 1, 1) != 0, rel_mask(e, 3, 1, 1) != 0, e < 4, e == 4);
    end
    run_to(29);

    // Single soft request at edge 30
    for (int e = 30; e <= 49; e++) begin
      m = (e < 38) ? 4'b1011 : 4'hF;
      push_a(e, m, m, 1'b0, 1'b0);
      push_b(e, e != 30, e != 30, 1'b0, 1'b0);
    end
    sw_a = 4'b0100;
    sw_b = 1'b1;
    run_to(30);
    sw_a = 4'h0;
    sw_b = 1'b0;
    run_to(49);

    // Re-armed soft request: edges 50 and 54 on A, 50 and 51 on B
    for (int e = 50; e <= 65; e++) begin
      m = (e < 62) ? 4'b1011 : 4'hF;
      push_a(e, m, m, 1'b0, 1'b0);
      push_b(e, e > 51, e > 51, 1'b0, 1'b0);
    end
    sw_a = 4'b0100;
    sw_b = 1'b1;
    run_to(50);
    sw_a = 4'h0;
    run_to(51);
    sw_b = 1'b0;
    run_to(53);
    sw_a = 4'b0100;
    run_to(54);
    sw_a = 4'h0;
    run_to(65);

    // Test-mode bypass is combinational; status keeps its own schedule
    test_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      test_rst_n = i[0];
      #1;
      cmp("tm_a_out",    out_a,          {4{i[0]}});
      cmp("tm_b_out",    {3'b0, out_b},  {3'b0, i[0]});
      cmp("tm_a_status", st_a,           4'hF);
    end
    test_rst_n = 1'b0;
    for (int e = 66; e <= 80; e++) begin
      m = (e >= 70 && e < 78) ? 4'b1011 : 4'hF;
      push_a(e, 4'h0, m, 1'b0, 1'b0);
      push_b(e, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    run_to(69);
    sw_a = 4'b0100;
    run_to(70);
    sw_a = 4'h0;
    run_to(80);
    test_mode = 1'b0;

    // Soft request coincident with s falling, then re-release without stretch
    for (int e = 81; e <= 110; e++) begin
      m = (e < 84) ? 4'hF : rel_mask(e, 88, 4, 4);
      push_a(e, m, m, (e < 84) ? 1'b0 : (e < 104), e == 104);
      push_b(e, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    run_to(81);
    rst_n_in_a = 1'b0;
    run_to(83);
    sw_a = 4'hF;
    run_to(84);
    sw_a = 4'h0;
    run_to(85);
    rst_n_in_a = 1'b1;
    run_to(110);

    // Async reset in the middle of a stretch
    push_a(111, 4'hF,    4'hF,    1'b0, 1'b0);
    push_b(111, 1'b1,    1'b1,    1'b0, 1'b0);
    push_a(112, 4'b1101, 4'b1101, 1'b0, 1'b0);
    push_b(112, 1'b1,    1'b1,    1'b0, 1'b0);
    run_to(111);
    sw_a = 4'b0010;
    run_to(112);
    sw_a = 4'h0;
    #2;
    rst_n_mux = 1'b0;
    #1;
    check_reset_now("async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_now("held");

    // Run 2: request drop mid-RELEASE, soft requests and test mode during RELEASE
    @(negedge clk);
    rst_n_mux = 1'b1;
    edge_no   = 0;
    for (int e = 1; e <= 40; e++) begin
      m = (e < 15) ? rel_mask(e, 3, 4, 4) : rel_mask(e, 22, 4, 4);
      push_a(e, (e >= 28 && e <= 31) ? 4'hF : m, m, e < 38, e == 38);
      push_b(e, rel_mask(e, 3, 1, 1) != 0, rel_mask(e, 3, 1, 1) != 0, e < 4, e == 4);
    end
    run_to(3);
    sw_a = 4'hF;
    run_to(12);
    sw_a       = 4'h0;
    rst_n_in_a = 1'b0;
    run_to(19);
    rst_n_in_a = 1'b1;
    run_to(25);
    sw_a = 4'hF;
    run_to(27);
    test_mode  = 1'b1;
    test_rst_n = 1'b1;
    run_to(31);
    test_mode  = 1'b0;
    test_rst_n = 1'b0;
    run_to(33);
    sw_a = 4'h0;
    run_to(40);

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
